control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer
Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  PC_W, 7, program counter / instruction address width (4..12)
  DADDR_W, 8, data memory address width (4..12)
  IMEM_LAT_MAX, 15, max imem response latency in cycles before fault
REQ-002 Ports (name  direction  width  meaning) SHALL be:
  Clk  in  1  single clock, rising edge
  Reset  in  1  asynchronous, active-high reset
  run  in  1  resume pulse from HALT or FAULT
  imem_req  out  1  one-cycle fetch request
  imem_addr  out  PC_W  fetch address, valid while imem_req=1
  imem_valid  in  1  fetch data valid strobe
  imem_data  in  16  fetched instruction
  alu_zero  in  1  datapath ALU result-is-zero flag
  D_Addr  out  DADDR_W  data memory address
  D_Wr  out  1  data memory write enable
  RF_s  out  1  RF write mux: 1=memory, 0=ALU
  RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr  out  4 each  register file addresses
  RF_W_en  out  1  RF write enable
  ALU_s0  out  3  ALU op: 0 pass, 1 add, 2 sub
  PC_Out  out  PC_W  current PC; IR_Out  out  16  instruction register
  outState, nextState  out  4 each  current / combinational next state
  halted, fault  out  1 each  HALT / FAULT state indicators
REQ-003 Clk and Reset are fixed: one clock; reset asynchronous, active-high.
Function
REQ-004 States SHALL be INIT=0, FETCH=1, WAIT=2, DECODE=3, NOOP=4, LOAD_A=5, LOAD_B=6, STORE=7, ADD=8, SUB=9, JUMP=10, BRZ=11, HALT=12, FAULT=13; codes 14-15 SHALL go to INIT.
REQ-005 INIT: PC<=0; next FETCH.
REQ-006 FETCH: imem_req=1, imem_addr=PC for exactly one cycle; next WAIT; latency counter cleared.
REQ-007 WAIT: on imem_valid, IR<=imem_data, PC<=PC+1 (wraps 2^PC_W-1 -> 0), next DECODE; after IMEM_LAT_MAX cycles with no imem_valid, next FAULT; imem_valid outside WAIT SHALL be ignored.
REQ-008 DECODE by IR[15:12]: 0 NOOP, 1 LOAD_A, 2 STORE, 3 ADD, 4 SUB, 5 HALT, 6 JUMP, 7 BRZ, 8-15 NOOP.
REQ-009 LOAD_A: D_Addr=IR[11:4], RF_s=1, RF_W_Addr=IR[3:0]; next LOAD_B, which holds same values plus RF_W_en=1; next FETCH.
REQ-010 STORE: D_Addr=IR[11:4], RF_Ra_Addr=IR[3:0], D_Wr=1 one cycle; next FETCH.
REQ-011 ADD/SUB: RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4], RF_W_Addr=IR[3:0], RF_s=0, RF_W_en=1, ALU_s0=1 (ADD) or 2 (SUB); next FETCH.
REQ-012 JUMP: PC<=IR[PC_W-1:0]; next FETCH.
REQ-013 BRZ: if alu_zero, PC<=PC+sign-extended IR[7:0], modulo 2^PC_W, relative to the already-incremented PC; else PC unchanged; next FETCH.
REQ-014 HALT/FAULT: halted resp. fault=1, PC and IR held; run=1 next FETCH (FAULT first re-fetches the same PC, i.e. PC not advanced).
REQ-015 IR[11:4] SHALL be truncated to DADDR_W if narrower, zero-extended if wider.
REQ-016 Every control output not named for a state SHALL be 0 in that state; all control outputs are combinational from state and IR.
Reset
REQ-017 Reset SHALL force state INIT, PC=0, IR=0, latency counter=0 immediately; all control outputs 0 while Reset=1.
REQ-018 Reset during WAIT SHALL discard the pending fetch; a later imem_valid SHALL not load IR.
Structure
REQ-019 Package control_sequencer_pkg SHALL hold the state enum, opcode enum and ALU_s0 constants.
REQ-020 PC SHALL be a sub-module pc_reg (clr, inc, load, load value, PC_W parameter).
Verification
REQ-021 Reset then imem_valid 1 cycle after req with NOOP stream -> PC_Out 0,1,2...; 2^PC_W-1 wraps to 0.
REQ-022 Latency 3 cycles, instr 0x3124 (ADD) -> RF_Ra_Addr=1, RF_Rb_Addr=2, RF_W_Addr=4, ALU_s0=1, RF_W_en=1 one cycle.
REQ-023 0x1A53 (LOAD) -> D_Addr=0xA5, RF_W_Addr=3, RF_s=1; RF_W_en=1 only in LOAD_B; 0x2A53 (STORE) -> D_Wr=1 one cycle.
REQ-024 PC=10 BRZ 0x70FC with alu_zero=1 -> next fetch addr 7; alu_zero=0 -> 11; 0x6005 JUMP -> 5.
REQ-025 No imem_valid for 15 cycles -> fault=1; run pulse -> refetch same PC; HALT 0x5000 then run -> fetch PC+1.
REQ-026 Reset asserted in WAIT, imem_valid after release -> IR_Out stays 0, state INIT then FETCH at PC 0.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared types and constants for the control sequencer.
//   state_t   : FSM state encoding, also visible on outState/nextState
//   opcode_t  : instruction opcode carried in IR[15:12]
//   ALU_*     : ALU_s0 operation codes driven to the datapath
package control_sequencer_pkg;

  localparam int IMEM_DATA_W = 16;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_WAIT   = 4'd2,
    ST_DECODE = 4'd3,
    ST_NOOP   = 4'd4,
    ST_LOAD_A = 4'd5,
    ST_LOAD_B = 4'd6,
    ST_STORE  = 4'd7,
    ST_ADD    = 4'd8,
    ST_SUB    = 4'd9,
    ST_JUMP   = 4'd10,
    ST_BRZ    = 4'd11,
    ST_HALT   = 4'd12,
    ST_FAULT  = 4'd13
  } state_t;

  // Opcodes 8..15 are not listed; they decode as NOOP.
  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_LOAD  = 4'd1,
    OP_STORE = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5,
    OP_JUMP  = 4'd6,
    OP_BRZ   = 4'd7
  } opcode_t;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/control_sequencer_if.sv
// Instruction-memory fetch interface.
// Handshake: the sequencer raises imem_req for exactly one cycle with
// imem_addr valid in that cycle. Memory answers some cycles later with a
// one-cycle imem_valid strobe carrying imem_data. There is no ready/backpressure;
// the sequencer accepts imem_valid only while it is waiting for a response.
//   master : sequencer side (drives req/addr, receives valid/data)
//   slave  : memory side
interface control_sequencer_if #(
  parameter int PC_W = 7
) ();
  import control_sequencer_pkg::*;

  logic                   imem_req;
  logic [PC_W-1:0]        imem_addr;
  logic                   imem_valid;
  logic [IMEM_DATA_W-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_data
  );
endinterface

// File: rtl/control_sequencer_pc_reg.sv
// Program counter register.
//   clk, rst     : clock, asynchronous active-high reset (PC -> 0)
//   clr_i        : synchronous clear to 0 (highest priority)
//   load_i       : load load_val_i
//   inc_i        : increment, wrapping modulo 2^PC_W
//   pc_o         : current PC
module pc_reg #(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            inc_i,
  input  logic            load_i,
  input  logic [PC_W-1:0] load_val_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (clr_i) begin
      pc_d = '0;
    end else if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetches 16-bit instructions over the imem
// interface, decodes them and drives register-file / ALU / data-memory
// control lines. All control outputs are combinational from state and IR.
//   Clk, Reset      : clock, asynchronous active-high reset
//   run             : resume from HALT or FAULT
//   imem            : fetch interface (master side)
//   alu_zero        : ALU zero flag used by BRZ
//   D_Addr, D_Wr    : data memory address / write enable
//   RF_*            : register file mux select, addresses, write enable
//   ALU_s0          : ALU operation
//   PC_Out, IR_Out  : current PC and instruction register
//   outState, nextState : current / next FSM state (debug)
//   halted, fault   : HALT / FAULT indicators
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int PC_W         = 7,
  parameter int DADDR_W      = 8,
  parameter int IMEM_LAT_MAX = 15
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               run,
  control_sequencer_if.master imem,
  input  logic               alu_zero,
  output logic [DADDR_W-1:0] D_Addr,
  output logic               D_Wr,
  output logic               RF_s,
  output logic [3:0]         RF_W_Addr,
  output logic [3:0]         RF_Ra_Addr,
  output logic [3:0]         RF_Rb_Addr,
  output logic               RF_W_en,
  output logic [2:0]         ALU_s0,
  output logic [PC_W-1:0]    PC_Out,
  output logic [15:0]        IR_Out,
  output logic [3:0]         outState,
  output logic [3:0]         nextState,
  output logic               halted,
  output logic               fault
);

  localparam int LAT_W = $clog2(IMEM_LAT_MAX + 1);

  state_t          state_q, state_d;
  logic [15:0]     ir_q;
  logic [LAT_W-1:0] lat_q;

  logic            pc_clr, pc_inc, pc_load;
  logic [PC_W-1:0] pc_load_val;
  logic [PC_W-1:0] pc;
  logic            ir_load;
  logic            lat_clr, lat_inc;
  logic [PC_W-1:0] brz_target;
  logic [DADDR_W-1:0] mem_addr;

  pc_reg #(.PC_W(PC_W)) u_pc_reg (
    .clk        (Clk),
    .rst        (Reset),
    .clr_i      (pc_clr),
    .inc_i      (pc_inc),
    .load_i     (pc_load),
    .load_val_i (pc_load_val),
    .pc_o       (pc)
  );

  // PC has already been incremented past the BRZ when it executes, so the
  // offset is relative to the following instruction. The 13-bit sign
  // extension covers every legal PC_W before truncating back.
  assign brz_target = pc + PC_W'({{5{ir_q[7]}}, ir_q[7:0]});

  // IR[11:4] zero-extended or truncated to the data address width.
  assign mem_addr = DADDR_W'(ir_q[11:4]);

  always_comb begin
    state_d        = state_q;
    imem.imem_req  = 1'b0;
    imem.imem_addr = '0;
    D_Addr         = '0;
    D_Wr           = 1'b0;
    RF_s           = 1'b0;
    RF_W_Addr      = '0;
    RF_Ra_Addr     = '0;
    RF_Rb_Addr     = '0;
    RF_W_en        = 1'b0;
    ALU_s0         = ALU_PASS;
    halted         = 1'b0;
    fault          = 1'b0;
    pc_clr         = 1'b0;
    pc_inc         = 1'b0;
    pc_load        = 1'b0;
    pc_load_val    = '0;
    ir_load        = 1'b0;
    lat_clr        = 1'b0;
    lat_inc        = 1'b0;

    case (state_q)
      ST_INIT: begin
        pc_clr  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = pc;
        lat_clr        = 1'b1;
        state_d        = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem.imem_valid) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = ST_DECODE;
        end else if (lat_q == LAT_W'(IMEM_LAT_MAX - 1)) begin
          // This is the IMEM_LAT_MAX-th empty wait cycle.
          state_d = ST_FAULT;
        end else begin
          lat_inc = 1'b1;
        end
      end
      ST_DECODE: begin
        case (opcode_t'(ir_q[15:12]))
          OP_NOOP:  state_d = ST_NOOP;
          OP_LOAD:  state_d = ST_LOAD_A;
          OP_STORE: state_d = ST_STORE;
          OP_ADD:   state_d = ST_ADD;
          OP_SUB:   state_d = ST_SUB;
          OP_HALT:  state_d = ST_HALT;
          OP_JUMP:  state_d = ST_JUMP;
          OP_BRZ:   state_d = ST_BRZ;
          default:  state_d = ST_NOOP;
        endcase
      end
      ST_NOOP: begin
        state_d = ST_FETCH;
      end
      ST_LOAD_A: begin
        D_Addr    = mem_addr;
        RF_s      = 1'b1;
        RF_W_Addr = ir_q[3:0];
        state_d   = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        // Second cycle gives the memory read a cycle to settle before the write.
        D_Addr    = mem_addr;
        RF_s      = 1'b1;
        RF_W_Addr = ir_q[3:0];
        RF_W_en   = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_STORE: begin
        D_Addr     = mem_addr;
        RF_Ra_Addr = ir_q[3:0];
        D_Wr       = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_ADD, ST_SUB: begin
        RF_Ra_Addr = ir_q[11:8];
        RF_Rb_Addr = ir_q[7:4];
        RF_W_Addr  = ir_q[3:0];
        RF_W_en    = 1'b1;
        ALU_s0     = (state_q == ST_ADD) ? ALU_ADD : ALU_SUB;
        state_d    = ST_FETCH;
      end
      ST_JUMP: begin
        pc_load     = 1'b1;
        pc_load_val = ir_q[PC_W-1:0];
        state_d     = ST_FETCH;
      end
      ST_BRZ: begin
        if (alu_zero) begin
          pc_load     = 1'b1;
          pc_load_val = brz_target;
        end
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (run) state_d = ST_FETCH;
      end
      ST_FAULT: begin
        // PC was never advanced for the failed fetch, so resuming retries it.
        fault = 1'b1;
        if (run) state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_INIT;
      ir_q    <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ir_load) ir_q <= imem.imem_data;
      if (lat_clr) begin
        lat_q <= '0;
      end else if (lat_inc) begin
        lat_q <= lat_q + LAT_W'(1);
      end
    end
  end

  assign PC_Out    = pc;
  assign IR_Out    = ir_q;
  assign outState  = state_q;
  assign nextState = state_d;

endmodule
